jk_ff_monitor: RTL and testbench

Downstream checking stage for the JK flip-flop. It observes the flip-flop's J/K inputs and its Q output on the shared clock and predicts the next Q from the JK truth table. It flags any divergence and counts hold/set/reset/toggle events. It sits beside the flip-flop in benches and in the on-chip self-test wrapper, and consumes Q without driving anything back.

---
 rtl/jk_ff_monitor.sv | 122 ++++++++++++
 tb/tb_jk_ff_monitor.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/jk_ff_monitor.sv
// jk_ff_monitor: passive checker for a JK flip-flop. It predicts the next Q
// from the observed Q and J/K, flags divergences (sticky and pulsed), and
// counts hold/set/reset/toggle events in saturating counters.
module jk_ff_monitor #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             j,
  input  logic             k,
  input  logic             q,
  output logic             armed,
  output logic             err,
  output logic             err_pulse,
  output logic [CNT_W-1:0] hold_cnt,
  output logic [CNT_W-1:0] set_cnt,
  output logic [CNT_W-1:0] reset_cnt,
  output logic [CNT_W-1:0] tgl_cnt,
  output logic [CNT_W-1:0] mis_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FAIL  = 2'd2
  } state_t;

  state_t state;
  logic   live;      // previous edge was enabled and not a clear
  logic   exp_q;     // predicted Q for the next edge
  logic   exp_next;
  logic   mismatch;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  // Prediction from observed Q and the JK truth table; compare gating.
  always_comb begin
    exp_next = q;
    unique case ({j, k})
      2'b00: exp_next = q;
      2'b10: exp_next = 1'b1;
      2'b01: exp_next = 1'b0;
      2'b11: exp_next = ~q;
      default: exp_next = q;
    endcase
    mismatch = en & ~clr & armed & (q != exp_q);
    // FAIL keeps its state across a disabled edge, so armed is qualified by live
    armed    = live & (state != IDLE);
  end

  // State machine and expectation register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      live  <= 1'b0;
      exp_q <= 1'b0;
    end else if (clr) begin
      state <= IDLE;
      live  <= 1'b0;
      exp_q <= 1'b0;
    end else if (!en) begin
      state <= (state == FAIL) ? FAIL : IDLE;
      live  <= 1'b0;
    end else begin
      live  <= 1'b1;
      exp_q <= exp_next;
      unique case (state)
        IDLE:    state <= ARMED;
        ARMED:   state <= mismatch ? FAIL : ARMED;
        FAIL:    state <= FAIL;
        default: state <= IDLE;
      endcase
    end
  end

  // Error flags and mismatch counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err       <= 1'b0;
      err_pulse <= 1'b0;
      mis_cnt   <= '0;
    end else if (clr) begin
      err       <= 1'b0;
      err_pulse <= 1'b0;
      mis_cnt   <= '0;
    end else begin
      err_pulse <= mismatch;
      if (mismatch) begin
        err     <= 1'b1;
        mis_cnt <= sat_inc(mis_cnt);
      end
    end
  end

  // Event classification counters on every enabled edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_cnt  <= '0;
      set_cnt   <= '0;
      reset_cnt <= '0;
      tgl_cnt   <= '0;
    end else if (clr) begin
      hold_cnt  <= '0;
      set_cnt   <= '0;
      reset_cnt <= '0;
      tgl_cnt   <= '0;
    end else if (en) begin
      unique case ({j, k})
        2'b00:   hold_cnt  <= sat_inc(hold_cnt);
        2'b10:   set_cnt   <= sat_inc(set_cnt);
        2'b01:   reset_cnt <= sat_inc(reset_cnt);
        2'b11:   tgl_cnt   <= sat_inc(tgl_cnt);
        default: hold_cnt  <= hold_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_jk_ff_monitor.sv
// tb_jk_ff_monitor: scoreboard bench. The driver advances a reference model
// built from the monitor's rules and queues expected outputs; a negedge
// monitor compares two instances (8-bit and 2-bit counters) against them.
module tb_jk_ff_monitor;
  logic clk = 1'b0;
  logic rst, en, clr, j, k, q;
  logic a8, e8, p8, a2, e2, p2;
  logic [7:0] h8, s8, r8, t8, m8;
  logic [1:0] h2, s2, r2, t2, m2;

  jk_ff_monitor #(.CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .j(j), .k(k), .q(q),
    .armed(a8), .err(e8), .err_pulse(p8),
    .hold_cnt(h8), .set_cnt(s8), .reset_cnt(r8), .tgl_cnt(t8), .mis_cnt(m8));

  jk_ff_monitor #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .j(j), .k(k), .q(q),
    .armed(a2), .err(e2), .err_pulse(p2),
    .hold_cnt(h2), .set_cnt(s2), .reset_cnt(r2), .tgl_cnt(t2), .mis_cnt(m2));

  always #5 clk = ~clk;

  typedef struct {
    bit armed; bit err; bit pulse;
    int h; int s; int r; int t; int m;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: raw event counts, clamped per counter width when checked.
  bit m_live, m_pred, m_err, m_pulse;
  int c_h, c_s, c_r, c_t, c_m;

  function automatic bit jk_rule(input bit qq, input bit jj, input bit kk);
    if (jj && kk) return !qq;
    if (jj) return 1'b1;
    if (kk) return 1'b0;
    return qq;
  endfunction

  function automatic int clamp(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_live = 0; m_pred = 0; m_err = 0; m_pulse = 0;
    c_h = 0; c_s = 0; c_r = 0; c_t = 0; c_m = 0;
  endtask

  // Effect of one clock edge given the inputs present at that edge.
  task automatic model_edge();
    if (!rst || clr) begin
      model_reset();
    end else if (!en) begin
      m_pulse = 0;
      m_live  = 0;
    end else begin
      m_pulse = m_live && (q != m_pred);
      if (m_pulse) begin
        c_m++;
        m_err = 1;
      end
      if (!j && !k) c_h++;
      else if (j && !k) c_s++;
      else if (!j && k) c_r++;
      else c_t++;
      m_pred = jk_rule(q, j, k);
      m_live = 1;
    end
  endtask

  // One cycle: apply the edge to the model, drive new inputs (q follows a
  // correct flip-flop unless f injects a wrong value), queue expectation.
  task automatic step(input bit r_i, input bit e_i, input bit c_i,
                      input bit j_i, input bit k_i, input bit f_i);
    bit nq;
    exp_t x;
    @(posedge clk);
    #1;
    model_edge();
    nq  = jk_rule(q, j, k);
    rst = r_i; en = e_i; clr = c_i; j = j_i; k = k_i;
    q   = f_i ? !nq : nq;
    if (!r_i) model_reset();
    x.armed = m_live; x.err = m_err; x.pulse = m_pulse;
    x.h = c_h; x.s = c_s; x.r = c_r; x.t = c_t; x.m = c_m;
    sb.push_back(x);
    cyc++;
  endtask

  task automatic check(input string nm, input bit a, input bit e, input bit p,
                       input int h, input int s, input int r, input int t,
                       input int m, input exp_t x, input int mx);
    n_cmp++;
    if (a !== x.armed || e !== x.err || p !== x.pulse ||
        h != clamp(x.h, mx) || s != clamp(x.s, mx) || r != clamp(x.r, mx) ||
        t != clamp(x.t, mx) || m != clamp(x.m, mx)) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got a=%b e=%b p=%b h=%0d s=%0d r=%0d t=%0d m=%0d exp a=%b e=%b p=%b h=%0d s=%0d r=%0d t=%0d m=%0d",
               nm, cyc, a, e, p, h, s, r, t, m, x.armed, x.err, x.pulse,
               clamp(x.h, mx), clamp(x.s, mx), clamp(x.r, mx),
               clamp(x.t, mx), clamp(x.m, mx));
    end
  endtask

  // Monitor: every negedge the DUTs present their post-edge outputs.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t x;
      x = sb.pop_front();
      check("w8", a8, e8, p8, int'(h8), int'(s8), int'(r8), int'(t8), int'(m8), x, 255);
      check("w2", a2, e2, p2, int'(h2), int'(s2), int'(r2), int'(t2), int'(m2), x, 3);
    end
  end

  initial begin
    bit [1:0] jk;
    rst = 0; en = 0; clr = 0; j = 0; k = 0; q = 0;
    model_reset();
    // reset, then idle with en=0
    repeat (2) step(0, 0, 0, 0, 0, 0);
    repeat (5) step(1, 0, 0, 0, 0, 0);
    // clean sequence from q=0
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 1, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 1, 0);
    step(1, 1, 0, 1, 1, 0);
    step(1, 1, 0, 1, 1, 0);
    step(1, 1, 0, 0, 0, 0);
    // injected fault: set, then wrong q; following cycles correct
    step(1, 1, 0, 1, 0, 0);
    step(1, 1, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 1, 1, 0);
    // disabled edge in FAIL, then re-enable
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 1, 1);
    step(1, 1, 0, 1, 0, 0);
    // clr with en; wrong q on clr edge and on first edge after are not compared
    step(1, 1, 1, 1, 1, 1);
    step(1, 1, 0, 0, 1, 1);
    step(1, 1, 0, 1, 0, 1);
    step(1, 1, 0, 1, 1, 0);
    step(1, 1, 0, 0, 0, 0);
    // async reset mid-run while err set and counters nonzero
    step(0, 1, 0, 1, 0, 0);
    step(0, 1, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    // saturation: toggling with correct q
    repeat (6) step(1, 1, 0, 1, 1, 0);
    // randomized traffic
    repeat (800) begin
      jk = 2'($urandom_range(0, 3));
      step($urandom_range(0, 199) != 0, $urandom_range(0, 9) != 0,
           $urandom_range(0, 39) == 0, jk[1], jk[0],
           $urandom_range(0, 14) == 0);
    end
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
